// File: rtl/rob_core.sv
// rob_core: circular reorder buffer with in-order commit and flush on branch misprediction.
// Define ROB_FORWARD_EN to enable combinational operand forwarding on the query ports.
module rob_core #(
    parameter int ROB_SIZE = 16,
    localparam int TAG_W = $clog2(ROB_SIZE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             in_fetcher_ce,
    input  logic [4:0]       in_alloc_dest_reg,
    input  logic             in_alloc_is_branch,
    input  logic             in_alloc_pred_taken,
    output logic [TAG_W-1:0] out_alloc_tag,
    output logic             out_full,
    input  logic             in_cdb_valid,
    input  logic [TAG_W-1:0] in_cdb_tag,
    input  logic [31:0]      in_cdb_value,
    input  logic             in_cdb_taken,
    input  logic [31:0]      in_cdb_target_pc,
    output logic [4:0]       out_commit_reg,
    output logic [TAG_W-1:0] out_commit_rob,
    output logic [31:0]      out_commit_value,
    output logic             out_misbranch,
    output logic [31:0]      out_misbranch_pc,
    input  logic [TAG_W-1:0] in_query_tag1,
    input  logic [TAG_W-1:0] in_query_tag2,
    output logic             out_query_ready1,
    output logic             out_query_ready2,
    output logic [31:0]      out_query_value1,
    output logic [31:0]      out_query_value2
);

    localparam logic [TAG_W:0]   FULL_CNT = (TAG_W+1)'(ROB_SIZE);
    localparam logic [TAG_W:0]   ONE_CNT  = (TAG_W+1)'(1);
    localparam logic [TAG_W-1:0] ONE_TAG  = TAG_W'(1);

    logic [ROB_SIZE-1:0] r_busy;
    logic [ROB_SIZE-1:0] r_ready;
    logic [ROB_SIZE-1:0] r_is_branch;
    logic [ROB_SIZE-1:0] r_pred_taken;
    logic [ROB_SIZE-1:0] r_taken;
    logic [4:0]          r_dest   [ROB_SIZE];
    logic [31:0]         r_value  [ROB_SIZE];
    logic [31:0]         r_target [ROB_SIZE];

    logic [TAG_W-1:0] r_head;
    logic [TAG_W-1:0] r_tail;
    logic [TAG_W:0]   r_count;

    logic [4:0]       r_commit_reg;
    logic [TAG_W-1:0] r_commit_rob;
    logic [31:0]      r_commit_value;
    logic             r_misbranch;
    logic [31:0]      r_misbranch_pc;

    logic w_full;
    logic w_alloc;
    logic w_wb;
    logic w_commit;
    logic w_mispredict;

    // Fullness is judged on the count at cycle start, so a same-cycle commit never frees a slot early.
    assign w_full       = (r_count == FULL_CNT);
    assign w_alloc      = rdy & in_fetcher_ce & ~w_full & ~r_misbranch;
    assign w_wb         = rdy & in_cdb_valid & r_busy[in_cdb_tag] & ~r_misbranch;
    assign w_commit     = rdy & r_busy[r_head] & r_ready[r_head];
    assign w_mispredict = w_commit & r_is_branch[r_head] & (r_taken[r_head] != r_pred_taken[r_head]);

    assign out_alloc_tag    = r_tail;
    assign out_full         = w_full;
    assign out_commit_reg   = r_commit_reg;
    assign out_commit_rob   = r_commit_rob;
    assign out_commit_value = r_commit_value;
    assign out_misbranch    = r_misbranch;
    assign out_misbranch_pc = r_misbranch_pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_ready <= '0;
        end else if (w_mispredict) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_busy  <= '0;
            r_ready <= '0;
        end else begin
            if (w_commit) begin
                r_busy[r_head] <= 1'b0;
                r_head         <= r_head + ONE_TAG;
            end
            if (w_alloc) begin
                r_busy[r_tail]  <= 1'b1;
                r_ready[r_tail] <= 1'b0;
                r_tail          <= r_tail + ONE_TAG;
            end
            if (w_wb) begin
                r_ready[in_cdb_tag] <= 1'b1;
            end
            case ({w_alloc, w_commit})
                2'b10:   r_count <= r_count + ONE_CNT;
                2'b01:   r_count <= r_count - ONE_CNT;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload fields need no reset: busy/ready alone decide whether an entry is meaningful.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_dest[r_tail]       <= in_alloc_dest_reg;
            r_is_branch[r_tail]  <= in_alloc_is_branch;
            r_pred_taken[r_tail] <= in_alloc_pred_taken;
        end
        if (w_wb) begin
            r_value[in_cdb_tag]  <= in_cdb_value;
            r_taken[in_cdb_tag]  <= in_cdb_taken;
            r_target[in_cdb_tag] <= in_cdb_target_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_commit_reg   <= '0;
            r_commit_rob   <= '0;
            r_commit_value <= '0;
            r_misbranch    <= 1'b0;
            r_misbranch_pc <= '0;
        end else if (rdy) begin
            r_commit_reg <= (w_commit && !r_is_branch[r_head]) ? r_dest[r_head] : 5'd0;
            if (w_commit) begin
                r_commit_rob   <= r_head;
                r_commit_value <= r_value[r_head];
            end
            r_misbranch <= w_mispredict;
            if (w_mispredict) begin
                r_misbranch_pc <= r_target[r_head];
            end
        end
    end

`ifdef ROB_FORWARD_EN
    // A same-cycle CDB write to the queried tag bypasses the entry so a consumer never misses it.
    always_comb begin
        out_query_ready1 = r_busy[in_query_tag1] & r_ready[in_query_tag1];
        out_query_value1 = r_value[in_query_tag1];
        out_query_ready2 = r_busy[in_query_tag2] & r_ready[in_query_tag2];
        out_query_value2 = r_value[in_query_tag2];
        if (w_wb && (in_cdb_tag == in_query_tag1)) begin
            out_query_ready1 = 1'b1;
            out_query_value1 = in_cdb_value;
        end
        if (w_wb && (in_cdb_tag == in_query_tag2)) begin
            out_query_ready2 = 1'b1;
            out_query_value2 = in_cdb_value;
        end
    end
`else
    logic w_unused_query;
    assign w_unused_query   = ^{in_query_tag1, in_query_tag2};
    assign out_query_ready1 = 1'b0;
    assign out_query_ready2 = 1'b0;
    assign out_query_value1 = '0;
    assign out_query_value2 = '0;
`endif

endmodule

// File: tb/tb_rob_core.sv
// tb_rob_core: randomized scoreboard bench for rob_core against a queue-based reorder-buffer model.
// The model follows ROB_FORWARD_EN the same way the design does.
module tb_rob_core;

    localparam int ROB = 16;

    logic        clk;
    logic        rst;
    logic        rdy;
    logic        fetcherCe;
    logic [4:0]  allocDest;
    logic        allocIsBranch;
    logic        allocPredTaken;
    logic [3:0]  outAllocTag;
    logic        outFull;
    logic        cdbValid;
    logic [3:0]  cdbTag;
    logic [31:0] cdbValue;
    logic        cdbTaken;
    logic [31:0] cdbTargetPc;
    logic [4:0]  outCommitReg;
    logic [3:0]  outCommitRob;
    logic [31:0] outCommitValue;
    logic        outMisbranch;
    logic [31:0] outMisbranchPc;
    logic [3:0]  queryTag1;
    logic [3:0]  queryTag2;
    logic        queryReady1;
    logic        queryReady2;
    logic [31:0] queryValue1;
    logic [31:0] queryValue2;

    rob_core #(.ROB_SIZE(ROB)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .rdy                 (rdy),
        .in_fetcher_ce       (fetcherCe),
        .in_alloc_dest_reg   (allocDest),
        .in_alloc_is_branch  (allocIsBranch),
        .in_alloc_pred_taken (allocPredTaken),
        .out_alloc_tag       (outAllocTag),
        .out_full            (outFull),
        .in_cdb_valid        (cdbValid),
        .in_cdb_tag          (cdbTag),
        .in_cdb_value        (cdbValue),
        .in_cdb_taken        (cdbTaken),
        .in_cdb_target_pc    (cdbTargetPc),
        .out_commit_reg      (outCommitReg),
        .out_commit_rob      (outCommitRob),
        .out_commit_value    (outCommitValue),
        .out_misbranch       (outMisbranch),
        .out_misbranch_pc    (outMisbranchPc),
        .in_query_tag1       (queryTag1),
        .in_query_tag2       (queryTag2),
        .out_query_ready1    (queryReady1),
        .out_query_ready2    (queryReady2),
        .out_query_value1    (queryValue1),
        .out_query_value2    (queryValue2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  tag;
        logic [4:0]  dest;
        bit          isBr;
        bit          pred;
        bit          done;
        logic [31:0] value;
        bit          taken;
        logic [31:0] target;
    } entry_t;

    typedef struct {
        bit          isMis;
        logic [4:0]  cReg;
        logic [3:0]  cRob;
        logic [31:0] cVal;
        logic [31:0] pc;
    } exp_t;

    entry_t robQ[$];
    exp_t   expQ[$];
    int     nextTag;
    bit     misPulse;
    int     checkCnt;
    int     errCnt;

    bit          sRdy, sCe, sIsBr, sPred, sCdbV, sTaken;
    logic [4:0]  sDest;
    logic [3:0]  sTag;
    logic [31:0] sVal, sTgt;

    function automatic void compare(input string name, input logic [31:0] got, input logic [31:0] want);
        checkCnt++;
        if (got !== want) begin
            errCnt++;
            $display("[TB] FAIL %s got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endfunction

    task automatic clearStim();
        sRdy = 1'b1; sCe = 1'b0; sIsBr = 1'b0; sPred = 1'b0; sCdbV = 1'b0; sTaken = 1'b0;
        sDest = 5'd0; sTag = 4'd0; sVal = 32'd0; sTgt = 32'd0;
    endtask

    task automatic wbStim(input logic [3:0] tag, input logic [31:0] val);
        sCdbV  = 1'b1;
        sTag   = tag;
        sVal   = val;
        sTaken = ($urandom_range(0, 1) == 1);
        sTgt   = $urandom;
    endtask

    // Reference model: an ordered list of in-flight instructions, advanced once per accepted clock.
    task automatic modelStep();
        bit     full, doCommit, mis;
        entry_t h, ne;
        exp_t   ex;
        if (!sRdy) return;
        full     = (robQ.size() == ROB);
        doCommit = (robQ.size() > 0) && robQ[0].done;
        mis      = 1'b0;
        if (doCommit) begin
            h   = robQ[0];
            mis = h.isBr && (h.taken != h.pred);
            if (!h.isBr && h.dest != 5'd0) begin
                ex.isMis = 1'b0; ex.cReg = h.dest; ex.cRob = h.tag; ex.cVal = h.value; ex.pc = 32'd0;
                expQ.push_back(ex);
            end
            if (mis) begin
                ex.isMis = 1'b1; ex.cReg = 5'd0; ex.cRob = 4'd0; ex.cVal = 32'd0; ex.pc = h.target;
                expQ.push_back(ex);
            end
        end
        if (sCdbV && !misPulse) begin
            foreach (robQ[i]) begin
                if (robQ[i].tag == sTag) begin
                    robQ[i].done = 1'b1; robQ[i].value = sVal;
                    robQ[i].taken = sTaken; robQ[i].target = sTgt;
                end
            end
        end
        if (doCommit) void'(robQ.pop_front());
        if (sCe && !full && !misPulse) begin
            ne.tag = 4'(nextTag); ne.dest = sDest; ne.isBr = sIsBr; ne.pred = sPred;
            ne.done = 1'b0; ne.value = 32'd0; ne.taken = 1'b0; ne.target = 32'd0;
            robQ.push_back(ne);
            nextTag = (nextTag + 1) % ROB;
        end
        if (mis) begin
            robQ.delete();
            nextTag = 0;
        end
        misPulse = mis;
    endtask

    function automatic void checkQuery(input logic [3:0] qTag, input logic qReady,
                                       input logic [31:0] qValue, input string name);
        bit          expReady;
        logic [31:0] expValue;
        bit          cdbHit;
        expReady = 1'b0;
        expValue = 32'd0;
        cdbHit   = 1'b0;
`ifdef ROB_FORWARD_EN
        foreach (robQ[i]) begin
            if (robQ[i].tag == qTag && robQ[i].done) begin
                expReady = 1'b1;
                expValue = robQ[i].value;
            end
            if (robQ[i].tag == sTag) cdbHit = 1'b1;
        end
        if (sRdy && sCdbV && cdbHit && !misPulse && sTag == qTag) begin
            expReady = 1'b1;
            expValue = sVal;
        end
        compare({name, "_ready"}, 32'(qReady), 32'(expReady));
        if (expReady) compare({name, "_value"}, qValue, expValue);
`else
        compare({name, "_ready"}, 32'(qReady), 32'(expReady));
        compare({name, "_value"}, qValue, expValue);
        if (cdbHit) expReady = 1'b0;
`endif
    endfunction

    task automatic checkOutput();
        compare("full", 32'(outFull), 32'(robQ.size() == ROB));
        compare("alloc_tag", 32'(outAllocTag), 32'(nextTag));
    endtask

    // Drive one cycle of stimulus at a falling edge and advance the model across the next rising edge.
    task automatic applyStimulus();
        rdy            = sRdy;
        fetcherCe      = sCe;
        allocDest      = sDest;
        allocIsBranch  = sIsBr;
        allocPredTaken = sPred;
        cdbValid       = sCdbV;
        cdbTag         = sTag;
        cdbValue       = sVal;
        cdbTaken       = sTaken;
        cdbTargetPc    = sTgt;
        queryTag1      = 4'($urandom_range(0, ROB - 1));
        queryTag2      = 4'($urandom_range(0, ROB - 1));
        #1;
        checkQuery(queryTag1, queryReady1, queryValue1, "query1");
        checkQuery(queryTag2, queryReady2, queryValue2, "query2");
        modelStep();
        @(negedge clk);
        checkOutput();
    endtask

    task automatic checkResetOutputs();
        compare("rst_commit_reg", 32'(outCommitReg), 32'd0);
        compare("rst_commit_rob", 32'(outCommitRob), 32'd0);
        compare("rst_commit_value", outCommitValue, 32'd0);
        compare("rst_misbranch", 32'(outMisbranch), 32'd0);
        compare("rst_misbranch_pc", outMisbranchPc, 32'd0);
        compare("rst_full", 32'(outFull), 32'd0);
        compare("rst_alloc_tag", 32'(outAllocTag), 32'd0);
    endtask

    task automatic doReset();
        #2 rst = 1'b1;
        #1 checkResetOutputs();
        robQ.delete();
        expQ.delete();
        nextTag  = 0;
        misPulse = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain();
        int guard;
        int idx;
        guard = 0;
        while ((robQ.size() != 0 || misPulse) && guard < 200) begin
            clearStim();
            idx = -1;
            foreach (robQ[i]) if (idx < 0 && !robQ[i].done) idx = i;
            if (idx >= 0) wbStim(robQ[idx].tag, $urandom);
            applyStimulus();
            guard++;
        end
        clearStim();
        repeat (3) applyStimulus();
        compare("drain_in_budget", 32'(guard < 200), 32'd1);
        compare("scoreboard_empty", 32'(expQ.size()), 32'd0);
    endtask

    task automatic randomStim();
        logic [3:0] pending[$];
        clearStim();
        sRdy  = ($urandom_range(0, 7) != 0);
        sCe   = ($urandom_range(0, 9) < 6);
        sDest = 5'($urandom_range(0, 31));
        sIsBr = ($urandom_range(0, 9) == 0);
        sPred = ($urandom_range(0, 1) == 1);
        foreach (robQ[i]) if (!robQ[i].done) pending.push_back(robQ[i].tag);
        if (pending.size() > 0 && $urandom_range(0, 99) < 55)
            wbStim(pending[$urandom_range(0, pending.size() - 1)], $urandom);
        else if ($urandom_range(0, 9) == 0)
            wbStim(4'($urandom_range(0, ROB - 1)), $urandom);
    endtask

    // Monitor: only outputs produced by a live (rdy, not reset) edge are new; otherwise they must hold.
    initial begin : monitorProc
        logic [4:0]  pReg;
        logic [3:0]  pRob;
        logic [31:0] pVal, pPc;
        logic        pMis;
        bit          eRdy, eRst;
        exp_t        ex;
        pReg = '0; pRob = '0; pVal = '0; pPc = '0; pMis = 1'b0;
        forever begin
            @(posedge clk);
            eRdy = rdy;
            eRst = rst;
            @(negedge clk);
            if (!eRst) begin
                if (!eRdy) begin
                    compare("hold_commit_reg", 32'(outCommitReg), 32'(pReg));
                    compare("hold_commit_rob", 32'(outCommitRob), 32'(pRob));
                    compare("hold_commit_value", outCommitValue, pVal);
                    compare("hold_misbranch", 32'(outMisbranch), 32'(pMis));
                    compare("hold_misbranch_pc", outMisbranchPc, pPc);
                end else if (outMisbranch || outCommitReg != 5'd0) begin
                    if (expQ.size() == 0) begin
                        checkCnt++;
                        errCnt++;
                        $display("[TB] FAIL unexpected_output got reg=%0d mis=%0b expected nothing at %0t",
                                 outCommitReg, outMisbranch, $time);
                    end else begin
                        ex = expQ.pop_front();
                        if (ex.isMis) begin
                            compare("misbranch_flag", 32'(outMisbranch), 32'd1);
                            compare("misbranch_pc", outMisbranchPc, ex.pc);
                            compare("misbranch_commit_reg", 32'(outCommitReg), 32'd0);
                        end else begin
                            compare("commit_reg", 32'(outCommitReg), 32'(ex.cReg));
                            compare("commit_rob", 32'(outCommitRob), 32'(ex.cRob));
                            compare("commit_value", outCommitValue, ex.cVal);
                            compare("commit_no_misbranch", 32'(outMisbranch), 32'd0);
                        end
                    end
                end
            end
            pReg = outCommitReg; pRob = outCommitRob; pVal = outCommitValue;
            pMis = outMisbranch; pPc = outMisbranchPc;
        end
    end

    initial begin : watchdogProc
        #1000000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] simulation did not complete");
    end

    initial begin : driverProc
        logic [3:0] t;
        checkCnt = 0;
        errCnt   = 0;
        nextTag  = 0;
        misPulse = 1'b0;
        rst      = 1'b1;
        clearStim();
        sRdy = 1'b0;
        rdy = 1'b0; fetcherCe = 1'b0; allocDest = '0; allocIsBranch = 1'b0; allocPredTaken = 1'b0;
        cdbValid = 1'b0; cdbTag = '0; cdbValue = '0; cdbTaken = 1'b0; cdbTargetPc = '0;
        queryTag1 = '0; queryTag2 = '0;
        repeat (3) @(negedge clk);
        checkResetOutputs();
        rst = 1'b0;

        $display("[TB] in-order commit of out-of-order write-backs");
        clearStim(); sCe = 1'b1;
        sDest = 5'd1; applyStimulus();
        sDest = 5'd2; applyStimulus();
        sDest = 5'd3; applyStimulus();
        clearStim(); wbStim(4'd2, 32'h20); applyStimulus();
        clearStim(); wbStim(4'd0, 32'h0A); applyStimulus();
        clearStim(); wbStim(4'd1, 32'h10); applyStimulus();
        drain();

        $display("[TB] full buffer and tail wrap");
        doReset();
        clearStim(); sCe = 1'b1;
        for (int i = 0; i < ROB; i++) begin
            sDest = 5'(i + 1);
            applyStimulus();
        end
        compare("full_after_16", 32'(outFull), 32'd1);
        sDest = 5'd30; applyStimulus();
        compare("alloc_tag_when_full", 32'(outAllocTag), 32'd0);
        clearStim(); wbStim(4'd0, 32'hABCD); applyStimulus();
        compare("full_before_commit", 32'(outFull), 32'd1);
        clearStim(); applyStimulus();
        compare("full_after_commit", 32'(outFull), 32'd0);
        compare("alloc_wrap_tag", 32'(outAllocTag), 32'd0);
        clearStim(); sCe = 1'b1; sDest = 5'd7; applyStimulus();
        compare("full_after_refill", 32'(outFull), 32'd1);
        drain();

        $display("[TB] mispredicted branch flush");
        doReset();
        clearStim(); sCe = 1'b1; sIsBr = 1'b1; sPred = 1'b0; applyStimulus();
        sIsBr = 1'b0; sDest = 5'd4; applyStimulus();
        sDest = 5'd5; applyStimulus();
        clearStim(); wbStim(4'd1, 32'h44); applyStimulus();
        clearStim(); wbStim(4'd2, 32'h55); applyStimulus();
        clearStim(); wbStim(4'd0, 32'h0); sTaken = 1'b1; sTgt = 32'h1000; applyStimulus();
        clearStim(); sCe = 1'b1; sDest = 5'd9; applyStimulus();
        compare("flush_pulse", 32'(outMisbranch), 32'd1);
        compare("flush_pc", outMisbranchPc, 32'h1000);
        compare("flush_alloc_tag", 32'(outAllocTag), 32'd0);
        applyStimulus();
        compare("flush_pulse_end", 32'(outMisbranch), 32'd0);
        compare("pulse_alloc_ignored", 32'(outAllocTag), 32'd0);
        sDest = 5'd10; applyStimulus();
        compare("post_flush_alloc", 32'(outAllocTag), 32'd1);
        drain();

        $display("[TB] correctly predicted branch");
        clearStim(); sCe = 1'b1; sIsBr = 1'b1; sPred = 1'b1;
        t = 4'(nextTag);
        applyStimulus();
        clearStim(); wbStim(t, 32'h77); sTaken = 1'b1; sTgt = 32'h2000; applyStimulus();
        clearStim(); applyStimulus();
        compare("good_branch_no_flush", 32'(outMisbranch), 32'd0);
        compare("good_branch_reg", 32'(outCommitReg), 32'd0);
        drain();

        $display("[TB] stall during commit stream, then reset mid-stream");
        clearStim(); sCe = 1'b1;
        for (int i = 0; i < 4; i++) begin
            sDest = 5'(11 + i);
            applyStimulus();
        end
        clearStim();
        for (int i = 0; i < 4; i++) begin
            wbStim(robQ[i].tag, 32'h100 + 32'(i));
            applyStimulus();
        end
        clearStim(); sRdy = 1'b0; sCe = 1'b1; sDest = 5'd20;
        repeat (5) applyStimulus();
        clearStim();
        repeat (4) applyStimulus();
        compare("stall_scoreboard_empty", 32'(expQ.size()), 32'd0);
        clearStim(); sCe = 1'b1;
        for (int i = 0; i < 3; i++) begin
            sDest = 5'(21 + i);
            applyStimulus();
        end
        clearStim(); wbStim(robQ[0].tag, 32'h321); applyStimulus();
        clearStim(); wbStim(robQ[1].tag, 32'h654); applyStimulus();
        doReset();
        clearStim(); sCe = 1'b1; sDest = 5'd6; applyStimulus();
        compare("post_reset_first_tag", 32'(outAllocTag), 32'd1);
        drain();

        $display("[TB] randomized traffic");
        for (int cyc = 0; cyc < 1500; cyc++) begin
            randomStim();
            applyStimulus();
            if ($urandom_range(0, 399) == 0) doReset();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checkCnt, errCnt);
        $finish;
    end

endmodule
